// File: rtl/alu_multibyte_seq.sv
// rtl/alu_multibyte_seq.sv - byte-serial sequencer driving a shared 8-bit ALU for N-byte add/sub/OR/AND
module alu_multibyte_seq #(
    parameter int NBYTES = 4,
    parameter int IDXW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [1:0]            alu_sel,
    output logic                  alu_cin,
    input  logic [7:0]            alu_res,
    input  logic                  alu_c,
    input  logic                  alu_even,
    input  logic                  alu_ov,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  flag_par,
    output logic                  flag_ov
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    state_t                     state_q;
    logic [IDXW-1:0]            idx_q;
    logic [NBYTES-1:0][7:0]     a_q;
    logic [NBYTES-1:0][7:0]     b_q;
    logic [NBYTES-1:0][7:0]     result_q;
    logic [1:0]                 op_q;
    logic                       cin_q;
    logic                       carry_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       flag_c_q;
    logic                       flag_z_q;
    logic                       flag_par_q;
    logic                       flag_ov_q;

    // Add (00) and subtract (01) chain carry/borrow; OR/AND have no chain.
    logic                       arith;
    logic                       last_byte;
    logic                       alu_cin_d;

    assign arith     = ~op_q[1];
    assign last_byte = (idx_q == LAST_IDX);

    // Chain input: external carry on byte 0, registered carry afterwards, forced 0 for logic ops.
    always_comb begin
        alu_cin_d = 1'b0;
        if (arith) begin
            alu_cin_d = (idx_q == '0) ? cin_q : carry_q;
        end
    end

    // ALU inputs are driven only while a byte is being processed; idle/done present zeros.
    always_comb begin
        alu_a   = 8'h00;
        alu_b   = 8'h00;
        alu_sel = 2'b00;
        alu_cin = 1'b0;
        if (state_q == S_RUN) begin
            alu_a   = a_q[idx_q];
            alu_b   = b_q[idx_q];
            alu_sel = op_q;
            alu_cin = alu_cin_d;
        end
    end

    // Sequencer FSM: latch request, walk bytes LSB first, accumulate result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 2'b00;
            cin_q      <= 1'b0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_par_q <= 1'b0;
            flag_ov_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q        <= op_a;
                        b_q        <= op_b;
                        op_q       <= op;
                        cin_q      <= cin;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        result_q   <= '0;
                        flag_par_q <= 1'b0;
                        flag_z_q   <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q[idx_q] <= alu_res;
                    carry_q         <= alu_c;
                    flag_z_q        <= flag_z_q & (alu_res == 8'h00);
                    flag_par_q      <= flag_par_q ^ alu_even;
                    idx_q           <= idx_q + IDXW'(1);
                    if (last_byte) begin
                        flag_c_q  <= arith ? alu_c  : 1'b0;
                        flag_ov_q <= arith ? alu_ov : 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign flag_c   = flag_c_q;
    assign flag_z   = flag_z_q;
    assign flag_par = flag_par_q;
    assign flag_ov  = flag_ov_q;

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// tb/tb_alu_multibyte_seq.sv - directed table-driven bench for alu_multibyte_seq with a behavioural ALU
module tb_alu_multibyte_seq;

    localparam int NBYTES = 4;
    localparam int IDXW   = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        cin;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_sel;
    logic        alu_cin;
    logic [7:0]  alu_res;
    logic        alu_c;
    logic        alu_even;
    logic        alu_ov;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        flag_c;
    logic        flag_z;
    logic        flag_par;
    logic        flag_ov;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    alu_multibyte_seq #(.NBYTES(NBYTES), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
        .op_a(op_a), .op_b(op_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_c(alu_c), .alu_even(alu_even), .alu_ov(alu_ov),
        .busy(busy), .done(done), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_par(flag_par), .flag_ov(flag_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU: carry out on add, borrow out on sub, signed overflow.
    logic [8:0] m_t;
    always_comb begin
        m_t      = 9'h000;
        alu_res  = 8'h00;
        alu_c    = 1'b0;
        alu_ov   = 1'b0;
        case (alu_sel)
            2'b00: begin
                m_t     = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
                alu_res = m_t[7:0];
                alu_c   = m_t[8];
                alu_ov  = (alu_a[7] == alu_b[7]) && (m_t[7] != alu_a[7]);
            end
            2'b01: begin
                m_t     = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
                alu_res = m_t[7:0];
                alu_c   = m_t[8];
                alu_ov  = (alu_a[7] != alu_b[7]) && (m_t[7] != alu_a[7]);
            end
            2'b10: alu_res = alu_a | alu_b;
            default: alu_res = alu_a & alu_b;
        endcase
        alu_even = ^alu_res;
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic [1:0]  op;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        par;
        logic        ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int edges;
        int busy_cnt;
        int cin_bad;
        int base;
        logic [31:0] held;
        @(negedge clk);
        op    = v.op;
        cin   = v.cin;
        op_a  = v.a;
        op_b  = v.b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        base     = done_cnt;
        edges    = 0;
        busy_cnt = 0;
        cin_bad  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cnt++;
            if (alu_cin !== 1'b0) cin_bad++;
            @(posedge clk);
            edges++;
        end
        check($sformatf("v%0d_latency", id), edges, NBYTES);
        check($sformatf("v%0d_busy_cycles", id), busy_cnt, NBYTES);
        check($sformatf("v%0d_busy_at_done", id), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_result", id), result, v.res);
        check($sformatf("v%0d_flag_c", id), {31'd0, flag_c}, {31'd0, v.c});
        check($sformatf("v%0d_flag_z", id), {31'd0, flag_z}, {31'd0, v.z});
        check($sformatf("v%0d_flag_par", id), {31'd0, flag_par}, {31'd0, v.par});
        check($sformatf("v%0d_flag_ov", id), {31'd0, flag_ov}, {31'd0, v.ov});
        if (v.op[1]) check($sformatf("v%0d_alu_cin_zero", id), cin_bad, 0);
        held = result;
        @(negedge clk);
        check($sformatf("v%0d_done_one_cycle", id), {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_result_hold", id), result, held);
        check($sformatf("v%0d_done_pulses", id), done_cnt - base, 1);
    endtask

    initial begin
        int base;
        vecs[0] = '{2'b00, 1'b0, 32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b00, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{2'b01, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 1'b1, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{2'b00, 1'b1, 32'h0000FFFF, 32'h00000000, 32'h00010000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{2'b01, 1'b1, 32'h00000005, 32'h00000003, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{2'b01, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        cin   = 1'b0;
        op_a  = 32'h0;
        op_b  = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {28'd0, flag_c, flag_z, flag_par, flag_ov}, 32'd0);
        check("rst_alu_out", {21'd0, alu_a, alu_b, alu_sel, alu_cin}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Second start during RUN is ignored, and operand changes mid-run have no effect.
        @(negedge clk);
        op = 2'b00; cin = 1'b0; op_a = 32'h00000001; op_b = 32'h00000002; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        base = done_cnt;
        @(posedge clk);
        #1 start = 1'b1; op = 2'b10; op_a = 32'hAAAAAAAA; op_b = 32'h55555555; cin = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("restart_done_pulses", done_cnt - base, 1);
        check("restart_result", result, 32'h00000003);
        check("restart_idle", {31'd0, busy}, 32'd0);

        // Reset during the second RUN cycle abandons the operation.
        @(negedge clk);
        op = 2'b00; cin = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'h00000001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        base = done_cnt;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_flag_z", {31'd0, flag_z}, 32'd0);
        check("midrst_alu_idle", {21'd0, alu_a, alu_b, alu_sel, alu_cin}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_done", done_cnt - base, 0);
        check("midrst_still_idle", {31'd0, busy}, 32'd0);

        run_vec(vecs[0], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
